// File: rtl/uart_fifo_ring_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART FIFO definitions.
//   uart_fifo_err_t : sticky error flags {overflow, underflow}, consumed by
//                     the UART status-register block.
//   UART_{TX,RX}_FIFO_{DEPTH,WIDTH} : default sizes of the TX/RX instances.
//   uart_fifo_lw()  : width of a level/threshold value for a given depth.
// Optional feature macro used by uart_fifo_ring: UART_FIFO_THRESH_EN.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } uart_fifo_err_t;

    localparam int UART_TX_FIFO_DEPTH = 16;
    localparam int UART_TX_FIFO_WIDTH = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_RX_FIFO_WIDTH = 8;

    // Level needs one extra bit over the index so that DEPTH itself fits.
    function automatic int uart_fifo_lw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ring_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_ring_if
// Handshake/status bundle between a UART data path and its ring FIFO.
//   master modport : the FIFO user (drives clear/push/pop/thresh/err_clr).
//   slave  modport : the FIFO itself (drives full/out_*/level/flags).
// Signals:
//   clear, push, in_data[WIDTH], pop, thresh[LW], err_clr  : user -> FIFO
//   full, out_valid, out_data[WIDTH], level[LW],
//   above_thresh, overflow, underflow                      : FIFO -> user
// DEPTH/WIDTH must match the parameters of the attached uart_fifo_ring.
// ---------------------------------------------------------------------------
interface uart_fifo_ring_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int WIDTH = UART_TX_FIFO_WIDTH
);
    localparam int LW = uart_fifo_lw(DEPTH);

    logic             clear;
    logic             push;
    logic [WIDTH-1:0] in_data;
    logic             full;
    logic             pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic [LW-1:0]    thresh;
    logic             above_thresh;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, in_data, pop, thresh, err_clr,
        input  full, out_valid, out_data, level, above_thresh, overflow, underflow
    );

    modport slave (
        input  clear, push, in_data, pop, thresh, err_clr,
        output full, out_valid, out_data, level, above_thresh, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_ring_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x WIDTH storage array for the UART ring FIFO: one synchronous write
// port, one asynchronous read port, contents reset to zero.
// Ports:
//   g_clk, g_resetn  : clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data : write port (takes effect at the g_clk edge)
//   rd_addr, rd_data        : combinational read port
// ---------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int WIDTH = UART_TX_FIFO_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Zeroing on reset keeps out_data at 0 straight after reset, before
    // any slot has been written.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_fifo_ring.sv
// ---------------------------------------------------------------------------
// uart_fifo_ring
// Circular-buffer FIFO for the UART TX/RX paths. Read/write pointers carry
// one wrap bit above the index, so full/empty and the occupancy count come
// straight from the pointers. First-word fall-through: out_data is the head.
// Ports:
//   g_clk, g_resetn : clock, synchronous active-low reset
//   g_clk_req       : high while any state-changing input is asserted
//   fifo (slave)    : clear/push/in_data/pop/thresh/err_clr in,
//                     full/out_valid/out_data/level/above_thresh/
//                     overflow/underflow out
// Optional feature: define UART_FIFO_THRESH_EN to build the level threshold
// comparator; otherwise above_thresh is tied 0 and thresh is ignored.
// ---------------------------------------------------------------------------
module uart_fifo_ring
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int WIDTH = UART_TX_FIFO_WIDTH
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    output logic            g_clk_req,
    uart_fifo_ring_if.slave fifo
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    uart_fifo_err_t   err_q, err_d;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] head_data;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A push into a full FIFO still goes in when a pop frees the head slot
    // in the same cycle. clear wins over everything and raises no errors.
    always_comb begin
        push_acc = fifo.push && (!full || fifo.pop) && !fifo.clear;
        pop_acc  = fifo.pop && !empty && !fifo.clear;
        ovf_set  = fifo.push && full && !fifo.pop && !fifo.clear;
        unf_set  = fifo.pop && empty && !fifo.clear;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + LW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + LW'(1);
            end
        end
    end

    // Error flags are sticky; a new error in the err_clr cycle must survive.
    always_comb begin
        err_d = err_q;
        if (fifo.err_clr) begin
            err_d = '0;
        end
        if (ovf_set) begin
            err_d.overflow = 1'b1;
        end
        if (unf_set) begin
            err_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // When full and popping, wr index equals rd index: the write lands in
    // the slot being vacated while the read still shows the old head.
    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .wr_en    (push_acc),
        .wr_addr  (wr_ptr_q[AW-1:0]),
        .wr_data  (fifo.in_data),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .rd_data  (head_data)
    );

    assign fifo.out_data  = head_data;
    assign fifo.full      = full;
    assign fifo.out_valid = !empty;
    assign fifo.level     = wr_ptr_q - rd_ptr_q;
    assign fifo.overflow  = err_q.overflow;
    assign fifo.underflow = err_q.underflow;

    assign g_clk_req = fifo.push | fifo.pop | fifo.clear | fifo.err_clr;

`ifdef UART_FIFO_THRESH_EN
    assign fifo.above_thresh = (fifo.thresh != '0) && (fifo.level >= fifo.thresh);
`else
    logic unused_thresh;
    assign unused_thresh     = ^fifo.thresh;
    assign fifo.above_thresh = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ring.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_ring
// Directed bench for uart_fifo_ring (DEPTH 16, WIDTH 8). Stimulus pushes the
// expected head data into a scoreboard queue; a monitor at the falling edge
// compares out_data whenever a pop is presented with out_valid, and also
// evaluates queued status expectations (level, flags, thresholds).
// ---------------------------------------------------------------------------
module tb_uart_fifo_ring;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int LW    = 5;

`ifdef UART_FIFO_THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] lvl;
        logic       full;
        logic       valid;
        logic       ovf;
        logic       unf;
        logic       above;
        logic       req;
        logic       chk_data;
        logic [7:0] data;
        logic       chk_sb;
    } exp_t;

    logic g_clk;
    logic g_resetn;
    logic g_clk_req;

    uart_fifo_ring_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fif ();

    uart_fifo_ring #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .g_clk_req (g_clk_req),
        .fifo      (fif.slave)
    );

    logic [7:0] sb_q [$];
    exp_t       exp_q [$];
    string      name_q [$];
    int         checks_total;
    int         checks_passed;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    function automatic void cmpVal(input string nm, input int act, input int req);
        checks_total++;
        if (act == req) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endfunction

    // Monitor: scoreboard compare on every presented pop, then any pending
    // status expectations.
    always @(negedge g_clk) begin
        if (fif.pop && fif.out_valid) begin
            if (sb_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL pop_data: actual 0x%02h required none (scoreboard empty)", fif.out_data);
            end else begin
                logic [7:0] want;
                want = sb_q.pop_front();
                cmpVal("pop_data", int'(fif.out_data), int'(want));
            end
        end
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmpVal({nm, ".level"},     int'(fif.level),        int'(e.lvl));
            cmpVal({nm, ".full"},      int'(fif.full),         int'(e.full));
            cmpVal({nm, ".out_valid"}, int'(fif.out_valid),    int'(e.valid));
            cmpVal({nm, ".overflow"},  int'(fif.overflow),     int'(e.ovf));
            cmpVal({nm, ".underflow"}, int'(fif.underflow),    int'(e.unf));
            cmpVal({nm, ".above"},     int'(fif.above_thresh), int'(e.above));
            cmpVal({nm, ".clk_req"},   int'(g_clk_req),        int'(e.req));
            if (e.chk_data) begin
                cmpVal({nm, ".out_data"}, int'(fif.out_data), int'(e.data));
            end
            if (e.chk_sb) begin
                cmpVal({nm, ".sb_left"}, sb_q.size(), 0);
            end
        end
    end

    // Called at posedge+1; holds inputs for exactly one active edge.
    task automatic applyStimulus(input bit p, input logic [7:0] d, input bit o,
                                 input bit c, input bit e);
        fif.push    = p;
        fif.in_data = d;
        fif.pop     = o;
        fif.clear   = c;
        fif.err_clr = e;
        @(posedge g_clk);
        #1;
        fif.push    = 1'b0;
        fif.in_data = '0;
        fif.pop     = 1'b0;
        fif.clear   = 1'b0;
        fif.err_clr = 1'b0;
    endtask

    // Queues an expectation for the monitor and lets one falling edge pass.
    task automatic checkOutput(input string nm, input int lvl, input bit full,
                               input bit valid, input bit ovf, input bit unf,
                               input bit above, input bit cd, input logic [7:0] d,
                               input bit req = 1'b0, input bit sb = 1'b0);
        exp_t e;
        e.lvl      = 8'(lvl);
        e.full     = full;
        e.valid    = valid;
        e.ovf      = ovf;
        e.unf      = unf;
        e.above    = above & THR_EN;
        e.req      = req;
        e.chk_data = cd;
        e.data     = d;
        e.chk_sb   = sb;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        g_resetn    = 1'b0;
        fif.push    = 1'b0;
        fif.in_data = '0;
        fif.pop     = 1'b0;
        fif.clear   = 1'b0;
        fif.err_clr = 1'b0;
        fif.thresh  = '0;
        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 1, 8'h00);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'(i));
            applyStimulus(1, 8'(i), 0, 0, 0);
        end
        checkOutput("fill16", 16, 1, 1, 0, 0, 0, 1, 8'h00);
        applyStimulus(1, 8'hAA, 0, 0, 0);
        checkOutput("overflow", 16, 1, 1, 1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("drain", 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("errclr1", 0, 0, 0, 0, 0, 0, 0, 8'h00);

        // 40 pushes with overlapping pops: index wraps twice.
        for (int i = 0; i < 40; i++) begin
            sb_q.push_back(8'(8'h40 + i));
            applyStimulus(1, 8'(8'h40 + i), (i >= 3), 0, 0);
        end
        checkOutput("wrap", 3, 0, 1, 0, 0, 0, 1, 8'h65);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("wrapdrain", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'(8'h80 + i));
            applyStimulus(1, 8'(8'h80 + i), 0, 0, 0);
        end
        checkOutput("full2", 16, 1, 1, 0, 0, 0, 1, 8'h80);
        sb_q.push_back(8'h55);
        applyStimulus(1, 8'h55, 1, 0, 0);
        checkOutput("fullpp", 16, 1, 1, 0, 0, 0, 1, 8'h81);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("fulldrain", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1);

        // Simultaneous push and pop while empty.
        sb_q.push_back(8'h33);
        applyStimulus(1, 8'h33, 1, 0, 0);
        checkOutput("emptypp", 1, 0, 1, 0, 1, 0, 1, 8'h33);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("errclr2", 1, 0, 1, 0, 0, 0, 1, 8'h33);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("pop33", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1);

        // Threshold behaviour.
        fif.thresh = LW'(4);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'(8'hC0 + i));
            applyStimulus(1, 8'(8'hC0 + i), 0, 0, 0);
            checkOutput($sformatf("thr4_l%0d", i + 1), i + 1, 0, 1, 0, 0, (i == 3), 1, 8'hC0);
        end
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("thr4_l3", 3, 0, 1, 0, 0, 0, 1, 8'hC1);
        fif.thresh = LW'(2);
        checkOutput("thr2", 3, 0, 1, 0, 0, 1, 1, 8'hC1);
        fif.thresh = LW'(0);
        checkOutput("thr0", 3, 0, 1, 0, 0, 0, 1, 8'hC1);
        sb_q.push_back(8'hC4);
        applyStimulus(1, 8'hC4, 0, 0, 0);
        checkOutput("thr0_l4", 4, 0, 1, 0, 0, 0, 1, 8'hC1);
        sb_q.push_back(8'hC5);
        applyStimulus(1, 8'hC5, 0, 0, 0);
        checkOutput("lvl5", 5, 0, 1, 0, 0, 0, 1, 8'hC1);

        // clear with push: everything discarded.
        sb_q.delete();
        applyStimulus(1, 8'hEE, 0, 1, 0);
        checkOutput("clear", 0, 0, 0, 0, 0, 0, 0, 8'h00);
        fif.clear = 1'b1;
        checkOutput("clkreq", 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        fif.clear = 1'b0;

        // Underflow, then reset in the middle of traffic.
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("popempty", 0, 0, 0, 0, 1, 0, 0, 8'h00);
        sb_q.push_back(8'h11);
        applyStimulus(1, 8'h11, 0, 0, 0);
        sb_q.push_back(8'h22);
        applyStimulus(1, 8'h22, 0, 0, 0);
        fif.thresh = LW'(1);
        checkOutput("prereset", 2, 0, 1, 0, 1, 1, 1, 8'h11);
        sb_q.delete();
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        checkOutput("midreset", 0, 0, 0, 0, 0, 0, 1, 8'h00);

        repeat (2) @(posedge g_clk);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ring.md
# uart_fifo_ring

Parametrised circular-buffer FIFO for the UART TX and RX data paths. It replaces the shift-register FIFO. Storage is a RAM-style array indexed by read and write pointers, so push-to-output latency is one cycle at any depth. It adds an occupancy count, a programmable level threshold, and sticky overflow/underflow error flags for the UART status register and interrupt logic.

## Interface
Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- WIDTH, 8, element width in bits.
- Derived: AW = $clog2(DEPTH); LW = AW+1, the width of level and thresh.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset; synchronous, active-low; clock g_clk.
- g_clk_req  out  1  clock request; high when any state-changing input is asserted.
- clear  in  1  discard all contents.
- push  in  1  write in_data this cycle.
- in_data  in  WIDTH  write data.
- full  out  1  level == DEPTH.
- pop  in  1  consume the head element this cycle.
- out_valid  out  1  level != 0.
- out_data  out  WIDTH  head element (first-word fall-through).
- level  out  LW  current occupancy, 0..DEPTH.
- thresh  in  LW  level threshold.
- above_thresh  out  1  level >= thresh, with thresh != 0.
- err_clr  in  1  clear both sticky error flags.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop arrived while empty.

## Operation
- State: wr_ptr and rd_ptr, LW bits each, with the MSB as the wrap bit; storage array mem[DEPTH].
- level = wr_ptr - rd_ptr, modulo 2^LW.
- full: pointer indices equal and wrap bits differ. Empty: pointers fully equal.
- Accepted push (push && (!full || pop)):
  - mem[wr_ptr[AW-1:0]] <= in_data.
  - wr_ptr increments and wraps naturally.
- Accepted pop (pop && out_valid): rd_ptr increments.
- push while full, no pop: data dropped, pointers unchanged, overflow <= 1.
- push && pop while full: both accepted.
  - The write targets the slot being vacated.
  - out_data shows the old head this cycle.
  - level stays DEPTH.
- pop while empty: ignored, underflow <= 1.
- push && pop while empty: push accepted, pop ignored, underflow <= 1. The next cycle has level 1.
- clear: wr_ptr and rd_ptr <= 0.
  - Overrides push and pop in the same cycle; no error flags are set from that cycle.
  - mem contents are not cleared.
  - Sticky flags are unaffected by clear.
- err_clr clears overflow and underflow. If a new error occurs in the same cycle, set wins.
- g_clk_req = push | pop | clear | err_clr.

## Timing
- Reset values: pointers 0; mem all zero; full 0; out_valid 0; level 0; out_data 0; above_thresh 0; overflow 0; underflow 0.
- Reset has priority over clear, push and pop.
- Registered: pointers, mem, flags.
- Combinational: full, out_valid, level, out_data and above_thresh, derived from registers (plus thresh).
- Push at edge N: out_valid, level and out_data update after edge N. Latency is 1 cycle at every DEPTH.
- pop samples the current out_data. The next head appears after the same edge.
- A thresh change affects above_thresh combinationally in the same cycle.
- Throughput: one push and one pop per cycle, sustained, at any occupancy including full and empty boundaries (except the empty push+pop case above).

## Configuration
- UART_FIFO_THRESH_EN defined: threshold comparator present; above_thresh = (thresh != 0) && (level >= thresh).
- Not defined: comparator removed, above_thresh tied 0, thresh ignored. Ports remain, so integration is unchanged.

## Structure
- Shared package uart_pkg holds:
  - typedef uart_fifo_err_t, a packed struct {overflow, underflow} used by the status-register block;
  - default DEPTH and WIDTH constants for the TX and RX instances.
- One sub-module, uart_fifo_mem: a DEPTH x WIDTH array with one synchronous write port and an asynchronous read port, reset to zero.
- Pointer, flag and threshold logic stays in uart_fifo_ring.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F (DEPTH 16):
  - full=1 and level=16 after the 16th edge.
  - 17th push of 0xAA: overflow=1, level=16.
  - 16 pops then return 0x00..0x0F in order.
- 40 pushes interleaved with pops, pointers wrapping twice: data order preserved; level never exceeds 16; no flags set.
- At full, push 0x55 with pop for one cycle:
  - popped value is the old head;
  - level stays 16;
  - 0x55 emerges last.
- While empty, push 0x33 with pop: underflow=1, level=1, out_data=0x33. Then err_clr with no errors: both flags return to 0.
- thresh=4, UART_FIFO_THRESH_EN defined: above_thresh rises on the edge where level reaches 4 and falls when level reaches 3. With thresh=0, above_thresh stays 0. Build without the macro: above_thresh stays 0 throughout.
- level=5, then clear asserted with push: level=0, out_valid=0, pushed data discarded. Asserting g_resetn low mid-stream returns every output to its reset value on the next edge.
